// File: rtl/axi_apb_pkg.sv
// Shared types, response codes and the acceptance-check helper for the AXI4-Lite to APB bridge.
package axi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Prioritised request check: alignment, then decode range, then partial-strobe writes.
  function automatic logic [1:0] check_resp(input logic misaligned,
                                            input logic out_of_range,
                                            input logic bad_strb);
    logic [1:0] resp;
    resp = RESP_OKAY;
    if (misaligned) begin
      resp = RESP_SLVERR;
    end else if (out_of_range) begin
      resp = RESP_DECERR;
    end else if (bad_strb) begin
      resp = RESP_SLVERR;
    end
    return resp;
  endfunction

endpackage

// File: rtl/apb_wdt.sv
// Watchdog for APB ACCESS wait states: flags the cycle in which the limit-th ACCESS cycle runs.
module apb_wdt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over counting so ACCESS always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge: one outstanding transaction, checked and watchdog-bounded.
module axi4lite_apb_bridge
  import axi_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [31:0] APB_ADDR_LIMIT = 32'h20,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    last_wr_q, last_wr_d;

  logic                    wr_req;
  logic                    rd_req;
  logic                    grant_wr;
  logic                    grant_rd;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [1:0]              req_resp;
  logic                    wdt_clear;
  logic                    wdt_en;
  logic                    wdt_expire;

  // Arbitration: alternate on ties, starting with the write after reset.
  always_comb begin
    wr_req   = awvalid && wvalid;
    rd_req   = arvalid;
    grant_wr = wr_req && (!rd_req || !last_wr_q);
    grant_rd = rd_req && (!wr_req || last_wr_q);
    req_addr = grant_wr ? awaddr : araddr;
    req_resp = check_resp(req_addr[1:0] != 2'b00,
                          req_addr >= ADDR_WIDTH'(APB_ADDR_LIMIT),
                          grant_wr && (wstrb != '1));
  end

  assign awready = presetn && (state_q == IDLE) && grant_wr;
  assign wready  = presetn && (state_q == IDLE) && grant_wr;
  assign arready = presetn && (state_q == IDLE) && grant_rd;

  apb_wdt #(
    .CNT_W (CNT_W)
  ) u_wdt (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (wdt_clear),
    .enable  (wdt_en),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expire  (wdt_expire)
  );

  // Next-state and registered-output logic; pwrite_q doubles as the transaction direction.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    last_wr_d = last_wr_q;
    wdt_clear = 1'b0;
    wdt_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_wr || grant_rd) begin
          paddr_d  = req_addr;
          pwrite_d = grant_wr;
          pwdata_d = grant_wr ? wdata : '0;
          if (req_resp != RESP_OKAY) begin
            state_d = RESP;
            if (grant_wr) begin
              bvalid_d = 1'b1;
              bresp_d  = req_resp;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = req_resp;
              rdata_d  = '0;
            end
          end else begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        wdt_clear = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        wdt_en = 1'b1;
        if (pready || wdt_expire) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
          if (pwrite_q) begin
            bvalid_d = 1'b1;
            bresp_d  = (pready && !pslverr) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = (pready && !pslverr) ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = pready ? prdata : '0;
          end
        end
      end

      RESP: begin
        if (pwrite_q ? bready : rready) begin
          bvalid_d  = 1'b0;
          rvalid_d  = 1'b0;
          last_wr_d = pwrite_q;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: doc/axi4lite_apb_bridge.md
# axi4lite_apb_bridge

AXI4-Lite slave to APB3 master bridge placed directly upstream of the APB register block (control and timer registers). It accepts one AXI4-Lite read or write at a time, runs a single APB SETUP/ACCESS transfer, and returns the APB result on the B or R channel. It also checks alignment, address range and write strobes, and bounds APB wait states with a watchdog.

## Interface
- ADDR_WIDTH, 32, AXI and APB address width
- DATA_WIDTH, 32, data width; only 32 is supported
- APB_ADDR_LIMIT, 32'h20, exclusive upper bound of decoded APB addresses
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for pready
- pclk  in  1  clock; all logic is on the rising edge
- presetn  in  1  reset: one clock; reset is synchronous and active-low
- awaddr  in  ADDR_WIDTH  write address
- awvalid / awready  in / out  1  write address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  write strobes
- wvalid / wready  in / out  1  write data handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  write response handshake
- araddr  in  ADDR_WIDTH  read address
- arvalid / arready  in / out  1  read address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  read response handshake
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- psel, penable, pwrite  out  1  APB control
- prdata  in  DATA_WIDTH  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, request detection:
  - A write request is awvalid && wvalid in the same cycle. A read request is arvalid.
  - If only one is present, grant it. If both are present, grant the type not served last. The `last_was_write` flag resets to 0, so the first tie goes to the write.
- Ready signals:
  - awready = wready = (IDLE && write granted). arready = (IDLE && read granted).
  - All three are combinational and forced to 0 while presetn is low.
- On acceptance, latch address, data and direction.
- Checks on acceptance, in this priority order:
  - addr[1:0] != 0: resp SLVERR (2'b10).
  - addr >= APB_ADDR_LIMIT: resp DECERR (2'b11).
  - Write with wstrb != all-ones: resp SLVERR.
  - On any error, go straight to RESP with no APB transfer and rdata = 0. Otherwise go to SETUP.
- SETUP: one cycle with psel=1, penable=0; paddr, pwrite and pwdata are valid. Then go to ACCESS.
- ACCESS: psel=1, penable=1, with paddr/pwrite/pwdata held stable.
  - pready=1: capture prdata (reads) and set resp = pslverr ? SLVERR : OKAY. Go to RESP.
  - Watchdog expiry: after TIMEOUT_CYCLES ACCESS cycles without pready, abort with resp SLVERR and rdata = 0, and go to RESP.
- RESP: psel=0, penable=0. Assert bvalid or rvalid with bresp/rresp (and rdata). Hold until bready/rready, then go to IDLE and update `last_was_write`.
- pwdata is driven only for writes; it is 0 for reads.

## Timing
- Reset, synchronous: at the first rising edge with presetn low, all registered outputs go to 0 and the state goes to IDLE. This covers psel, penable, pwrite, paddr, pwdata, bvalid, bresp, rvalid, rresp and rdata.
- Reset mid-operation: any in-flight transaction is dropped with no response, psel drops at that edge, and `last_was_write` returns to 0.
- Write latency, no wait states: handshake in cycle T, SETUP in T+1, ACCESS in T+2 with pready sampled, bvalid in T+3.
- Wait states: each APB wait state adds one cycle of latency. The watchdog counter starts at 0 on ACCESS entry and increments each ACCESS cycle. A pready arriving in the same cycle as expiry wins.
- Error path: handshake in cycle T, response valid in T+1.
- bvalid/rvalid stay stable until accepted. No new AXI request is accepted until the response handshake completes, so at most one transaction is outstanding.
- Minimum gap between consecutive APB transfers is 2 cycles of psel=0 (RESP plus IDLE).

## Structure
- Package `axi_apb_pkg` holds:
  - `state_t` enum (IDLE, SETUP, ACCESS, RESP).
  - Response localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module `apb_wdt`: watchdog counter with inputs clear, enable and limit, and output expire. The bridge clears it on entry to ACCESS.

## Test plan
- Write awaddr=0x4, wdata=0x12345678, wstrb=0xF, pready after 2 wait states -> one APB transfer with paddr=4, pwrite=1; bresp=OKAY; a readback of 0x4 returns rdata=0x12345678, rresp=OKAY.
- Read araddr=0x8 with pready in the first ACCESS cycle -> rvalid exactly 3 cycles after arvalid&&arready; rdata equals prdata.
- Write awvalid and arvalid both high out of reset -> write granted first and read second; psel never overlaps; both responses OKAY.
- Misaligned araddr=0x5, then awaddr=0x40, then wstrb=0x3 -> SLVERR, DECERR and SLVERR respectively; psel stays 0 throughout; rdata=0 for the read.
- pready held 0, or pslverr=1 at completion -> SLVERR; timeout occurs after 16 ACCESS cycles; rdata=0 on timeout.
- presetn pulled low during ACCESS -> psel=0 and bvalid=0 at the next edge; no response appears; the next write completes normally.
